// File: rtl/fb_pkg.sv
// fb_pkg: shared widths, requester identity and read-tag types for the
// framebuffer port arbiter and its tag pipeline.
package fb_pkg;

  localparam int FB_ADDR_WIDTH = 12;
  localparam int FB_DATA_WIDTH = 8;

  typedef logic reqId_t;

  typedef struct packed {
    logic   valid;
    reqId_t requester;
  } tag_t;

  typedef enum logic [1:0] {
    LOCK_IDLE = 2'd0,
    LOCK_0    = 2'd1,
    LOCK_1    = 2'd2
  } lockState_t;

  function automatic tag_t makeTag(input logic isRead, input reqId_t who);
    tag_t t;
    t.valid     = isRead;
    t.requester = who;
    return t;
  endfunction

endpackage

// File: rtl/fb_tag_pipe.sv
// fb_tag_pipe: DEPTH-stage shift register carrying {valid, requester} for
// every accepted beat so the read data leaving the RAM can be routed back to
// the requester that issued it. DEPTH matches the RAM read latency (1..4).
module fb_tag_pipe
  import fb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk_in,
  input  logic reset,
  input  tag_t push_i,
  output tag_t tail_o
);

  tag_t stage_q [DEPTH];

  // Shift one tag in every cycle; reset throws away all in-flight reads
  always_ff @(posedge clk_in) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= push_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tail_o = stage_q[DEPTH-1];

endmodule

// File: rtl/framebuffer_port_arbiter.sv
// framebuffer_port_arbiter: shares framebuffer port A between the UART
// control module (requester 0) and an on-chip engine (requester 1).
// Round-robin arbitration with same-cycle grant, combinational RAM drive from
// the winner, and tagged routing of read data back to the issuer.
// Optional macro FBARB_LOCK_EN adds a lock FSM so one requester can keep the
// port for atomic multi-beat pixel updates.
module framebuffer_port_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH   = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH   = FB_DATA_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic                  req0_lock,
  input  logic [ADDR_WIDTH-1:0] req0_address,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic                  req1_lock,
  input  logic [ADDR_WIDTH-1:0] req1_address,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  ram_write_enable,
  output logic                  ram_clk_enable,
  output logic                  ram_reset,
  input  logic [DATA_WIDTH-1:0] ram_data_in
);

  logic                  lastGrant_q, lastGrant_d;
  logic [ADDR_WIDTH-1:0] addrHold_q, addrHold_d;
  logic [DATA_WIDTH-1:0] dataHold_q, dataHold_d;
  logic                  elig0, elig1;
  logic                  grant0, grant1;
  logic                  accept;
  reqId_t                winner;
  logic [ADDR_WIDTH-1:0] winAddr;
  logic [DATA_WIDTH-1:0] winData;
  logic                  winWrite;
  tag_t                  pushTag, tailTag;

`ifdef FBARB_LOCK_EN
  lockState_t lock_q, lock_d;
  logic       winLock;

  assign winLock = winner ? req1_lock : req0_lock;

  // Lock state register
  always_ff @(posedge clk_in) begin
    if (reset) begin
      lock_q <= LOCK_IDLE;
    end else begin
      lock_q <= lock_d;
    end
  end

  // Each accepted beat either claims the port for its requester or releases it
  always_comb begin
    lock_d = lock_q;
    if (accept) begin
      if (winLock) begin
        lock_d = winner ? LOCK_1 : LOCK_0;
      end else begin
        lock_d = LOCK_IDLE;
      end
    end
  end

  assign elig0 = req0_valid && !reset && (lock_q != LOCK_1);
  assign elig1 = req1_valid && !reset && (lock_q != LOCK_0);
`else
  logic unusedLock;

  assign unusedLock = req0_lock | req1_lock;
  assign elig0      = req0_valid && !reset;
  assign elig1      = req1_valid && !reset;
`endif

  // Round-robin pick: a lone requester wins at once, a tie goes to whoever did not win last
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && elig1) begin
      grant0 = lastGrant_q;
      grant1 = !lastGrant_q;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  assign accept = grant0 | grant1;
  assign winner = grant1;

  // Select the winning requester's beat for the RAM bus
  always_comb begin
    winAddr  = req0_address;
    winData  = req0_data;
    winWrite = req0_write;
    if (winner == 1'b1) begin
      winAddr  = req1_address;
      winData  = req1_data;
      winWrite = req1_write;
    end
  end

  // Round-robin pointer and RAM bus holding registers
  always_ff @(posedge clk_in) begin
    if (reset) begin
      lastGrant_q <= 1'b1;
      addrHold_q  <= '0;
      dataHold_q  <= '0;
    end else begin
      lastGrant_q <= lastGrant_d;
      addrHold_q  <= addrHold_d;
      dataHold_q  <= dataHold_d;
    end
  end

  // Only an accepted beat moves the pointer or changes what the bus holds
  always_comb begin
    lastGrant_d = lastGrant_q;
    addrHold_d  = addrHold_q;
    dataHold_d  = dataHold_q;
    if (accept) begin
      lastGrant_d = winner;
      addrHold_d  = winAddr;
      dataHold_d  = winData;
    end
  end

  assign req0_ready       = grant0;
  assign req1_ready       = grant1;
  assign ram_clk_enable   = accept;
  assign ram_write_enable = accept && winWrite;
  assign ram_address      = accept ? winAddr : addrHold_q;
  assign ram_data_out     = accept ? winData : dataHold_q;
  assign ram_reset        = reset;

  assign pushTag = makeTag(accept && !winWrite, winner);

  fb_tag_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_tagPipe (
    .clk_in (clk_in),
    .reset  (reset),
    .push_i (pushTag),
    .tail_o (tailTag)
  );

  assign rsp0_valid = !reset && tailTag.valid && (tailTag.requester == 1'b0);
  assign rsp1_valid = !reset && tailTag.valid && (tailTag.requester == 1'b1);
  assign rsp0_data  = ram_data_in;
  assign rsp1_data  = ram_data_in;

endmodule

// File: tb/tb_framebuffer_port_arbiter.sv
// Bench for framebuffer_port_arbiter: two instances (read latency 1 and 3)
// share one set of requester inputs, each with its own RAM model. A driver
// advances an abstract reference model of the arbitration rules and queues
// the expected per-cycle bus activity and read responses; a monitor pops and
// compares them against what each instance presents.
module tb_framebuffer_port_arbiter;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;

  always #5 clk_in = ~clk_in;

  logic          req0_valid, req0_write, req0_lock;
  logic [AW-1:0] req0_address;
  logic [DW-1:0] req0_data;
  logic          req1_valid, req1_write, req1_lock;
  logic [AW-1:0] req1_address;
  logic [DW-1:0] req1_data;

  logic          a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid;
  logic [DW-1:0] a_rsp0_data, a_rsp1_data, a_ram_data_out, a_ram_data_in;
  logic [AW-1:0] a_ram_address;
  logic          a_ram_we, a_ram_ce, a_ram_reset;

  logic          b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid;
  logic [DW-1:0] b_rsp0_data, b_rsp1_data, b_ram_data_out, b_ram_data_in;
  logic [AW-1:0] b_ram_address;
  logic          b_ram_we, b_ram_ce, b_ram_reset;

  framebuffer_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT_A)) dutA (
    .clk_in(clk_in), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_lock(req0_lock),
    .req0_address(req0_address), .req0_data(req0_data), .req0_ready(a_req0_ready),
    .rsp0_valid(a_rsp0_valid), .rsp0_data(a_rsp0_data),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_lock(req1_lock),
    .req1_address(req1_address), .req1_data(req1_data), .req1_ready(a_req1_ready),
    .rsp1_valid(a_rsp1_valid), .rsp1_data(a_rsp1_data),
    .ram_address(a_ram_address), .ram_data_out(a_ram_data_out),
    .ram_write_enable(a_ram_we), .ram_clk_enable(a_ram_ce),
    .ram_reset(a_ram_reset), .ram_data_in(a_ram_data_in)
  );

  framebuffer_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT_B)) dutB (
    .clk_in(clk_in), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_lock(req0_lock),
    .req0_address(req0_address), .req0_data(req0_data), .req0_ready(b_req0_ready),
    .rsp0_valid(b_rsp0_valid), .rsp0_data(b_rsp0_data),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_lock(req1_lock),
    .req1_address(req1_address), .req1_data(req1_data), .req1_ready(b_req1_ready),
    .rsp1_valid(b_rsp1_valid), .rsp1_data(b_rsp1_data),
    .ram_address(b_ram_address), .ram_data_out(b_ram_data_out),
    .ram_write_enable(b_ram_we), .ram_clk_enable(b_ram_ce),
    .ram_reset(b_ram_reset), .ram_data_in(b_ram_data_in)
  );

  function automatic logic [DW-1:0] initVal(input logic [AW-1:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]};
  endfunction

  bit [DW:0]     memA [4096];
  bit [DW:0]     memB [4096];
  logic [DW-1:0] bRd, bD1;

  // Framebuffer model for instance A: registered read, one cycle
  always @(posedge clk_in) begin
    if (a_ram_ce) begin
      a_ram_data_in <= memA[a_ram_address][DW] ? memA[a_ram_address][DW-1:0] : initVal(a_ram_address);
      if (a_ram_we) memA[a_ram_address] <= {1'b1, a_ram_data_out};
    end
  end

  // Framebuffer model for instance B: registered read followed by two extra delay stages
  always @(posedge clk_in) begin
    if (b_ram_ce) begin
      bRd <= memB[b_ram_address][DW] ? memB[b_ram_address][DW-1:0] : initVal(b_ram_address);
      if (b_ram_we) memB[b_ram_address] <= {1'b1, b_ram_data_out};
    end
    bD1           <= bRd;
    b_ram_data_in <= bD1;
  end

  typedef struct {
    bit            v;
    bit            w;
    bit            l;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } txn_t;

  typedef struct {
    bit            rst;
    bit            r0;
    bit            r1;
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } grantExp_t;

  typedef struct {
    int            who;
    logic [DW-1:0] d;
    int            due;
  } rspExp_t;

  txn_t          pend [2];
  grantExp_t     grantQ [$];
  rspExp_t       rspQa [$];
  rspExp_t       rspQb [$];
  logic [DW-1:0] refMem [int];
  int            mLast = 1;
  int            mLock = -1;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  // Free-running cycle counter used to time responses
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, actual, expected);
    end
  endtask

  task automatic setPend(input int n, input bit w, input bit l, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[n].v = 1'b1;
    pend[n].w = w;
    pend[n].l = l;
    pend[n].a = a;
    pend[n].d = d;
  endtask

  task automatic applyStimulus(input bit rst);
    grantExp_t     g;
    rspExp_t       r;
    int            win;
    bit            e0, e1;
    logic [DW-1:0] rd;
    @(posedge clk_in);
    #1;
    reset        = rst;
    req0_valid   = pend[0].v;
    req0_write   = pend[0].w;
    req0_lock    = pend[0].l;
    req0_address = pend[0].a;
    req0_data    = pend[0].d;
    req1_valid   = pend[1].v;
    req1_write   = pend[1].w;
    req1_lock    = pend[1].l;
    req1_address = pend[1].a;
    req1_data    = pend[1].d;
    g.rst = rst;
    g.r0  = 1'b0;
    g.r1  = 1'b0;
    g.we  = 1'b0;
    g.a   = '0;
    g.d   = '0;
    if (rst) begin
      mLast = 1;
      mLock = -1;
      rspQa.delete();
      rspQb.delete();
    end else begin
      e0  = pend[0].v && (mLock < 0 || mLock == 0);
      e1  = pend[1].v && (mLock < 0 || mLock == 1);
      win = -1;
      if (e0 && e1) win = 1 - mLast;
      else if (e0)  win = 0;
      else if (e1)  win = 1;
      if (win >= 0) begin
        g.r0 = (win == 0);
        g.r1 = (win == 1);
        g.we = pend[win].w;
        g.a  = pend[win].a;
        g.d  = pend[win].d;
        if (pend[win].w) begin
          refMem[int'(pend[win].a)] = pend[win].d;
        end else begin
          rd    = refMem.exists(int'(pend[win].a)) ? refMem[int'(pend[win].a)] : initVal(pend[win].a);
          r.who = win;
          r.d   = rd;
          r.due = cyc + LAT_A;
          rspQa.push_back(r);
          r.due = cyc + LAT_B;
          rspQb.push_back(r);
        end
        mLast = win;
`ifdef FBARB_LOCK_EN
        mLock = pend[win].l ? win : -1;
`endif
        pend[win].v = 1'b0;
      end
    end
    grantQ.push_back(g);
  endtask

  task automatic checkRsp(input int dutId, input logic v0, input logic v1, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    rspExp_t r;
    bit      have;
    have = (dutId == 0) ? (rspQa.size() > 0) : (rspQb.size() > 0);
    if (have) r = (dutId == 0) ? rspQa[0] : rspQb[0];
    if (v0 || v1) begin
      if (have) begin
        if (dutId == 0) void'(rspQa.pop_front());
        else            void'(rspQb.pop_front());
        checkOutput(dutId == 0 ? "A.rsp0Valid" : "B.rsp0Valid", v0, r.who == 0);
        checkOutput(dutId == 0 ? "A.rsp1Valid" : "B.rsp1Valid", v1, r.who == 1);
        checkOutput(dutId == 0 ? "A.rspData" : "B.rspData", v1 ? d1 : d0, r.d);
        checkOutput(dutId == 0 ? "A.rspCycle" : "B.rspCycle", cyc, r.due);
      end else begin
        checkOutput(dutId == 0 ? "A.rspSpurious" : "B.rspSpurious", v0 | v1, 0);
      end
    end else if (have && r.due <= cyc) begin
      if (dutId == 0) void'(rspQa.pop_front());
      else            void'(rspQb.pop_front());
      checkOutput(dutId == 0 ? "A.rspMissing" : "B.rspMissing", v0 | v1, 1);
    end
  endtask

  // Monitor: on each falling edge compare both instances with the queued expectations
  initial begin : monitor
    grantExp_t g;
    forever begin
      @(negedge clk_in);
      if (grantQ.size() > 0) begin
        g = grantQ.pop_front();
        checkOutput("A.req0Ready", a_req0_ready, g.r0);
        checkOutput("A.req1Ready", a_req1_ready, g.r1);
        checkOutput("A.ramClkEn", a_ram_ce, g.r0 | g.r1);
        checkOutput("A.ramWe", a_ram_we, g.we);
        checkOutput("A.ramReset", a_ram_reset, g.rst);
        checkOutput("B.req0Ready", b_req0_ready, g.r0);
        checkOutput("B.req1Ready", b_req1_ready, g.r1);
        checkOutput("B.ramClkEn", b_ram_ce, g.r0 | g.r1);
        checkOutput("B.ramWe", b_ram_we, g.we);
        checkOutput("B.ramReset", b_ram_reset, g.rst);
        if (g.r0 || g.r1) begin
          checkOutput("A.ramAddress", a_ram_address, g.a);
          checkOutput("A.ramDataOut", a_ram_data_out, g.d);
          checkOutput("B.ramAddress", b_ram_address, g.a);
          checkOutput("B.ramDataOut", b_ram_data_out, g.d);
        end
        checkRsp(0, a_rsp0_valid, a_rsp1_valid, a_rsp0_data, a_rsp1_data);
        checkRsp(1, b_rsp0_valid, b_rsp1_valid, b_rsp0_data, b_rsp1_data);
      end
    end
  end

  task automatic flushPend();
    for (int i = 0; i < 8 && (pend[0].v || pend[1].v); i++) applyStimulus(1'b0);
  endtask

  function automatic logic [AW-1:0] pickAddr();
    if ($urandom_range(0, 4) == 0) return 12'h7FF;
    return 12'($urandom_range(0, 15));
  endfunction

  // Stimulus sequence: directed scenarios, then randomized traffic with occasional resets
  initial begin : stimulus
    int k0, k1;
    bit rst;
    pend[0].v = 1'b0;
    pend[1].v = 1'b0;
    req0_valid = 1'b0; req0_write = 1'b0; req0_lock = 1'b0; req0_address = '0; req0_data = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_lock = 1'b0; req1_address = '0; req1_data = '0;

    repeat (3) applyStimulus(1'b1);

    setPend(0, 1'b0, 1'b0, 12'h123, 8'h00);
    repeat (3) applyStimulus(1'b0);

    applyStimulus(1'b1);
    k0 = 0;
    k1 = 0;
    for (int i = 0; i < 8; i++) begin
      if (!pend[0].v) begin setPend(0, 1'b1, 1'b0, 12'(12'h010 + k0), 8'(8'h30 + k0)); k0++; end
      if (!pend[1].v) begin setPend(1, 1'b0, 1'b0, 12'(12'h020 + k1), 8'h00); k1++; end
      applyStimulus(1'b0);
    end
    flushPend();

    setPend(1, 1'b1, 1'b0, 12'h7FF, 8'hA5);
    applyStimulus(1'b0);
    setPend(0, 1'b0, 1'b0, 12'h7FF, 8'h00);
    repeat (2) applyStimulus(1'b0);

    setPend(0, 1'b0, 1'b0, 12'h055, 8'h00);
    applyStimulus(1'b0);
    repeat (2) applyStimulus(1'b1);
    setPend(0, 1'b0, 1'b0, 12'h011, 8'h00);
    setPend(1, 1'b0, 1'b0, 12'h012, 8'h00);
    applyStimulus(1'b0);
    flushPend();

    applyStimulus(1'b1);
    for (int i = 0; i < 10; i++) begin
      if (!pend[0].v) setPend(0, 1'b0, 1'b0, 12'(12'h200 + i), 8'h00);
      if (!pend[1].v) setPend(1, 1'b0, 1'b0, 12'(12'h300 + i), 8'h00);
      applyStimulus(1'b0);
    end
    flushPend();

`ifdef FBARB_LOCK_EN
    applyStimulus(1'b1);
    k0 = 0;
    for (int i = 0; i < 5; i++) begin
      if (!pend[0].v && k0 < 3) begin setPend(0, 1'b1, (k0 < 2), 12'(12'h040 + k0), 8'(8'h60 + k0)); k0++; end
      if (!pend[1].v) setPend(1, 1'b0, 1'b0, 12'h041, 8'h00);
      applyStimulus(1'b0);
    end
    flushPend();
`endif

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int n = 0; n < 2; n++) begin
        if (!pend[n].v && $urandom_range(0, 3) != 0)
          setPend(n, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), pickAddr(), 8'($urandom));
      end
      applyStimulus(rst);
    end

    pend[0].v = 1'b0;
    pend[1].v = 1'b0;
    repeat (6) applyStimulus(1'b0);
    @(negedge clk_in);
    #1;
    checkOutput("A.rspQueueEmpty", rspQa.size(), 0);
    checkOutput("B.rspQueueEmpty", rspQb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/framebuffer_port_arbiter.md
Name: framebuffer_port_arbiter

Overview:
- Shares the single framebuffer port A (8-bit data, 12-bit address, 1-cycle registered read) between two requesters.
  - Requester 0: the UART control module.
  - Requester 1: a future on-chip engine (fill, scroll or test-pattern generator).
- Sits between the requesters and the framebuffer port-A pins on clk_in.
- Provides valid/ready request handshakes, round-robin arbitration and tagged read-response routing back to the issuing requester.

Parameters:
- ADDR_WIDTH, 12, framebuffer port-A address width
- DATA_WIDTH, 8, framebuffer port-A data width
- READ_LATENCY, 1, cycles from accepted read to valid ram_data_in (legal 1..4)

Ports:
- clk_in  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a transaction
- req0_write  input  1  1 = write, 0 = read
- req0_lock  input  1  hold grant after this beat (used only with FBARB_LOCK_EN)
- req0_address  input  ADDR_WIDTH  target address
- req0_data  input  DATA_WIDTH  write data
- req0_ready  output  1  transaction accepted this cycle
- rsp0_valid  output  1  read data for requester 0 valid
- rsp0_data  output  DATA_WIDTH  read data
- req1_*, rsp1_*  same set as requester 0, for requester 1
- ram_address  output  ADDR_WIDTH  to framebuffer AddressA
- ram_data_out  output  DATA_WIDTH  to framebuffer DataInA
- ram_write_enable  output  1  to WrA
- ram_clk_enable  output  1  to ClockEnA
- ram_reset  output  1  to ResetA; equals reset
- ram_data_in  input  DATA_WIDTH  from QA

Behaviour:
- Handshake
  - A transaction is accepted in the cycle where reqN_valid && reqN_ready.
  - Requester holds address, data, write and lock stable while valid && !ready.
  - reqN_ready is combinational from the current valid inputs and arbiter state. It is never asserted to both requesters in the same cycle.
  - Throughput: one transaction per cycle.
- Arbitration
  - Register last_grant; reset value 1, so requester 0 wins the first tie.
  - Only one requester valid: it is granted in the same cycle.
  - Both valid: the requester != last_grant wins.
  - last_grant updates on every accept.
  - Worst-case wait for a continuously valid requester: 1 cycle.
- RAM drive (combinational from the winner)
  - Winner's fields drive ram_address and ram_data_out.
  - ram_write_enable = accepted && write.
  - ram_clk_enable = any accept.
  - No accept: ram_clk_enable = 0, ram_write_enable = 0, address and data hold the last driven values.
- Read return
  - Tag shift register, READ_LATENCY deep, of {valid, requester}; entry pushed on every accepted read. Writes push an invalid entry.
  - At the pipeline tail: rspN_valid = tail.valid && tail.requester == N.
  - rsp0_data = rsp1_data = ram_data_in, unregistered.
  - Reads to the same address as a write accepted in the same or earlier cycle return the RAM's read-during-write value; the arbiter adds no hazard logic.
- Reset (synchronous)
  - Clears the tag pipeline; in-flight reads are discarded and produce no rspN_valid.
  - Sets last_grant = 1 and lock state = IDLE.
  - While reset is high: both reqN_ready = 0, ram_clk_enable = 0, ram_write_enable = 0.
  - Reset values of outputs: rspN_valid = 0, reqN_ready = 0, ram_* enables = 0.
- Back-to-back
  - A requester may be granted in consecutive cycles only while the other is idle (or locked out, see below).

Optional Feature:
- FBARB_LOCK_EN defined:
  - Lock FSM with states IDLE, LOCK0, LOCK1.
  - Beat accepted from requester N with reqN_lock = 1 → LOCKN.
  - In LOCKN only requester N can receive ready; the other requester waits regardless of round-robin.
  - Beat accepted from N with reqN_lock = 0 → IDLE.
  - Reset → IDLE.
  - A lock held by an idle requester stalls the other indefinitely; this is by design, for atomic multi-byte pixel updates.
- FBARB_LOCK_EN undefined:
  - reqN_lock inputs are ignored and no FSM is built.
  - Pure round-robin.

Decomposition:
- Shared package fb_pkg:
  - FB_ADDR_WIDTH = 12, FB_DATA_WIDTH = 8.
  - Requester-ID type (1 bit) and tag struct {valid, requester}.
- One natural sub-module, fb_tag_pipe: the parameterised READ_LATENCY-deep tag shift register with synchronous clear.
- Arbitration and lock FSM stay in the top.

Test Plan:
- Reset release, req0 read 0x123 alone:
  - req0_ready same cycle; ram_address = 0x123, ram_clk_enable = 1, ram_write_enable = 0.
  - rsp0_valid one cycle later with RAM value; rsp1_valid stays 0.
- Both valid continuously, req0 writes 0x010..., req1 reads 0x020...:
  - Grants alternate 0,1,0,1 starting with 0.
  - Exactly one ready per cycle; read responses appear only on rsp1.
- Write 0xA5 to 0x7FF via req1, then read 0x7FF via req0:
  - rsp0_data = 0xA5, one cycle after the read accept.
- Read accepted from req0, reset asserted the next cycle:
  - No rsp0_valid ever asserts.
  - Outputs at reset values; first grant after reset goes to req0 on a tie.
- FBARB_LOCK_EN, req0 issues 3 beats with lock = 1,1,0 while req1 is continuously valid:
  - req1_ready = 0 for all 3 beats; req1 granted in the cycle after the final beat.
- READ_LATENCY = 3, alternating reads req0/req1 every cycle:
  - Responses arrive 3 cycles after each accept, in issue order, routed to the correct requester.
